// File: rtl/wav_sample_pacer.sv
// Paces stereo PCM frames out of the SD read FIFO at SAMPLE_RATE using a fractional
// phase accumulator; splits, attenuates and presents samples for the PDM modulators.
module wav_sample_pacer #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SAMPLE_RATE = 44_100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play_en,
  input  logic        FIFO_PREFETCHED,
  input  logic [31:0] WAV_FILE_LEN,
  input  logic        fifo_rdempty,
  input  logic [31:0] q,
  output logic        FIFO_RD_EN,
  input  logic [2:0]  vol_shift,
  output logic [15:0] pcm_l,
  output logic [15:0] pcm_r,
  output logic [15:0] pcm_lu,
  output logic [15:0] pcm_ru,
  output logic        sample_valid,
  output logic        play_done,
  output logic [15:0] underrun_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] phase_q, phase_d;
  logic [32:0] phase_sum;
  logic        phase_wrap;
  logic [29:0] total_q, total_d;
  logic [29:0] frame_cnt_q, frame_cnt_d;
  logic        pop_q, pop_d;
  logic        urun_q, urun_d;
  logic        s2_pop_q, s2_urun_q;
  logic        valid_q, valid_d;
  logic [15:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic [15:0] urun_cnt_q, urun_cnt_d;

  logic        start_play;
  logic        last_popped;
  logic        last_delivered;
  logic        is_idle, is_run, is_done;
  logic        tick;

  assign start_play     = play_en && FIFO_PREFETCHED;
  assign last_popped    = (frame_cnt_q == total_q);
  // The final frame's sample_valid is the only pulse seen once every frame has been popped.
  assign last_delivered = last_popped && valid_q;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_play) begin
          state_d = (WAV_FILE_LEN[31:2] == 30'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_delivered) begin
          state_d = StDone;
        end else if (!play_en) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (last_delivered) begin
          state_d = StDone;
        end else if (play_en) begin
          state_d = StRun;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    is_idle   = (state_q == StIdle);
    is_run    = (state_q == StRun);
    is_done   = (state_q == StDone);
    play_done = is_done;
  end

  // Rate generator
  assign phase_sum  = {1'b0, phase_q} + 33'(SAMPLE_RATE);
  assign phase_wrap = (phase_sum >= 33'(CLK_HZ));
  assign tick       = is_run && phase_wrap && !last_popped;

  always_comb begin
    phase_d = phase_q;
    if (is_idle) begin
      phase_d = 32'd0;
    end else if (is_run) begin
      phase_d = phase_wrap ? 32'(phase_sum - 33'(CLK_HZ)) : phase_sum[31:0];
    end
  end

  // Frame accounting and pop / underrun pipeline
  always_comb begin
    total_d     = total_q;
    frame_cnt_d = frame_cnt_q;
    urun_cnt_d  = urun_cnt_q;
    pop_d       = tick && !fifo_rdempty;
    urun_d      = tick && fifo_rdempty;
    if (is_idle && start_play) begin
      total_d = WAV_FILE_LEN[31:2];
    end
    if (pop_d) begin
      frame_cnt_d = frame_cnt_q + 30'd1;
    end
    if (urun_d && (urun_cnt_q != 16'hFFFF)) begin
      urun_cnt_d = urun_cnt_q + 16'd1;
    end
  end

  // Sample capture: q is valid the cycle after the pop strobe.
  always_comb begin
    valid_d = s2_pop_q || s2_urun_q;
    pcm_l_d = pcm_l_q;
    pcm_r_d = pcm_r_q;
    if (is_done) begin
      pcm_l_d = 16'd0;
      pcm_r_d = 16'd0;
    end else if (s2_pop_q) begin
      pcm_l_d = 16'($signed(q[31:16]) >>> vol_shift);
      pcm_r_d = 16'($signed(q[15:0]) >>> vol_shift);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= 32'd0;
      total_q     <= 30'd0;
      frame_cnt_q <= 30'd0;
      pop_q       <= 1'b0;
      urun_q      <= 1'b0;
      s2_pop_q    <= 1'b0;
      s2_urun_q   <= 1'b0;
      valid_q     <= 1'b0;
      pcm_l_q     <= 16'd0;
      pcm_r_q     <= 16'd0;
      urun_cnt_q  <= 16'd0;
    end else begin
      phase_q     <= phase_d;
      total_q     <= total_d;
      frame_cnt_q <= frame_cnt_d;
      pop_q       <= pop_d;
      urun_q      <= urun_d;
      s2_pop_q    <= pop_q;
      s2_urun_q   <= urun_q;
      valid_q     <= valid_d;
      pcm_l_q     <= pcm_l_d;
      pcm_r_q     <= pcm_r_d;
      urun_cnt_q  <= urun_cnt_d;
    end
  end

  assign FIFO_RD_EN   = pop_q;
  assign sample_valid = valid_q;
  assign pcm_l        = pcm_l_q;
  assign pcm_r        = pcm_r_q;
  assign pcm_lu       = pcm_l_q ^ 16'h8000;
  assign pcm_ru       = pcm_r_q ^ 16'h8000;
  assign underrun_cnt = urun_cnt_q;

endmodule
